// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes, functs, datapath selects.
// MC_JUMP_EN adds the JUMP state.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10
`ifdef MC_JUMP_EN
    ,
    S_JUMP   = 4'd11
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: decode inputs from IR/ALU/memory, strobes and selects back.
interface multicycle_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       ir_write;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] pc_src;
  logic [1:0] alu_src_b;
  logic [2:0] alu_ctrl;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_write, ir_write, iord, mem_read, mem_write, mem_to_reg,
           reg_dst, reg_write, alu_src_a, pc_src, alu_src_b, alu_ctrl
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_write, ir_write, iord, mem_read, mem_write, mem_to_reg,
           reg_dst, reg_write, alu_src_a, pc_src, alu_src_b, alu_ctrl
  );
endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// R-type funct field to ALU operation; unknown functs flag funct_illegal and select and (000).
module alu_decoder
  import mc_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_ctrl,
  output logic       funct_illegal
);

  always_comb begin
    alu_ctrl      = ALU_AND;
    funct_illegal = 1'b0;
    case (funct)
      FN_ADD:  alu_ctrl = ALU_ADD;
      FN_SUB:  alu_ctrl = ALU_SUB;
      FN_AND:  alu_ctrl = ALU_AND;
      FN_OR:   alu_ctrl = ALU_OR;
      FN_SLT:  alu_ctrl = ALU_SLT;
      default: funct_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM with retired-instruction counter.
// Define MC_JUMP_EN to decode opcode 000010 as j; otherwise it is illegal.
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  multicycle_ctrl_if.master     bus,
  output logic                  illegal,
  output logic [3:0]            state,
  output logic [CNT_W-1:0]      retired
);

  state_t     cur;
  state_t     nxt;
  logic       retire;
  logic [2:0] fn_ctrl;
  logic       fn_illegal;

  alu_decoder u_alu_decoder (
    .funct        (bus.funct),
    .alu_ctrl     (fn_ctrl),
    .funct_illegal(fn_illegal)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur     <= S_FETCH;
      retired <= '0;
    end else begin
      cur <= nxt;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

  assign state = cur;

  // Outputs decode only while out of reset so every strobe drops as soon as rst falls.
  always_comb begin
    nxt            = cur;
    retire         = 1'b0;
    illegal        = 1'b0;
    bus.pc_write   = 1'b0;
    bus.ir_write   = 1'b0;
    bus.iord       = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.reg_write  = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.pc_src     = PC_ALU;
    bus.alu_src_b  = SRCB_REG;
    bus.alu_ctrl   = ALU_AND;
    if (rst) begin
      case (cur)
        S_FETCH: begin
          bus.mem_read  = 1'b1;
          bus.alu_src_b = SRCB_FOUR;
          bus.alu_ctrl  = ALU_ADD;
          if (bus.mem_ready) begin
            bus.ir_write = 1'b1;
            bus.pc_write = 1'b1;
            nxt          = S_DECODE;
          end
        end
        S_DECODE: begin
          bus.alu_src_b = SRCB_IMM_SH;
          bus.alu_ctrl  = ALU_ADD;
          case (bus.opcode)
            OP_LW, OP_SW: nxt = S_MEMADR;
            OP_RTYPE:     nxt = S_EXEC;
            OP_BEQ:       nxt = S_BRANCH;
            OP_ADDI:      nxt = S_ADDIEX;
`ifdef MC_JUMP_EN
            OP_J:         nxt = S_JUMP;
`endif
            default: begin
              nxt     = S_FETCH;
              illegal = 1'b1;
            end
          endcase
        end
        S_MEMADR: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = SRCB_IMM;
          bus.alu_ctrl  = ALU_ADD;
          nxt           = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        end
        S_MEMRD: begin
          bus.iord     = 1'b1;
          bus.mem_read = 1'b1;
          if (bus.mem_ready) nxt = S_MEMWB;
        end
        S_MEMWR: begin
          bus.iord      = 1'b1;
          bus.mem_write = 1'b1;
          if (bus.mem_ready) begin
            nxt    = S_FETCH;
            retire = 1'b1;
          end
        end
        S_MEMWB: begin
          bus.mem_to_reg = 1'b1;
          bus.reg_write  = 1'b1;
          nxt            = S_FETCH;
          retire         = 1'b1;
        end
        S_EXEC: begin
          bus.alu_src_a = 1'b1;
          bus.alu_ctrl  = fn_ctrl;
          if (fn_illegal) begin
            illegal = 1'b1;
            nxt     = S_FETCH;
          end else begin
            nxt = S_ALUWB;
          end
        end
        S_ALUWB: begin
          bus.reg_dst   = 1'b1;
          bus.reg_write = 1'b1;
          nxt           = S_FETCH;
          retire        = 1'b1;
        end
        S_BRANCH: begin
          bus.alu_src_a = 1'b1;
          bus.alu_ctrl  = ALU_SUB;
          bus.pc_src    = PC_ALUOUT;
          bus.pc_write  = bus.zero;
          nxt           = S_FETCH;
          retire        = 1'b1;
        end
        S_ADDIEX: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = SRCB_IMM;
          bus.alu_ctrl  = ALU_ADD;
          nxt           = S_ADDIWB;
        end
        S_ADDIWB: begin
          bus.reg_write = 1'b1;
          nxt           = S_FETCH;
          retire        = 1'b1;
        end
`ifdef MC_JUMP_EN
        S_JUMP: begin
          bus.pc_src   = PC_JUMP;
          bus.pc_write = 1'b1;
          nxt          = S_FETCH;
          retire       = 1'b1;
        end
`endif
        default: nxt = S_FETCH;
      endcase
    end
  end

endmodule
